// File: rtl/multicycle_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// MULTICYCLE_FSM_PERF_EN adds the InstRet retired-instruction counter.
interface multicycle_fsm_if;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic        MemReady;
  logic        IRWrite;
  logic        NextPC;
  logic        RegW;
  logic        MemW;
  logic        Branch;
  logic        ALUOp;
  logic        AdrSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic        Undef;
  logic [3:0]  State;
`ifdef MULTICYCLE_FSM_PERF_EN
  logic [15:0] InstRet;
`endif

  modport master (
    input  Op, Funct, MemReady,
    output IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
    output ALUSrcA, ALUSrcB, ResultSrc, Undef, State
`ifdef MULTICYCLE_FSM_PERF_EN
    , output InstRet
`endif
  );

  modport slave (
    output Op, Funct, MemReady,
    input  IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc,
    input  ALUSrcA, ALUSrcB, ResultSrc, Undef, State
`ifdef MULTICYCLE_FSM_PERF_EN
    , input InstRet
`endif
  );
endinterface

// File: rtl/multicycle_fsm.sv
// Multicycle processor main controller: Moore FSM with registered control outputs.
// Define MULTICYCLE_FSM_PERF_EN to add the 16-bit InstRet retired-instruction counter.
module multicycle_fsm (
  input logic              clk,
  input logic              reset,
  multicycle_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch, StDecode: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      StMemAdr:   c.alu_src_b = 2'b01;
      StMemRead:  c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      StMemWrite: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      StExecR:    c.alu_op = 1'b1;
      StExecI: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 1'b1;
      end
      StAluWb:    c.reg_w = 1'b1;
      StBranch: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:    state_d = bus.MemReady ? StDecode : StFetch;
      StDecode: begin
        unique case (bus.Op)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = bus.Funct[5] ? StExecI : StExecR;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = bus.Funct[0] ? StMemRead : StMemWrite;
      StMemRead:  state_d = bus.MemReady ? StMemWb : StMemRead;
      StMemWrite: state_d = bus.MemReady ? StFetch : StMemWrite;
      StExecR,
      StExecI:    state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  // Control word is precomputed from the next state so outputs come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      ctrl_q  <= decode(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  // Fetch strobes follow MemReady combinationally; reset masks them.
  assign bus.IRWrite   = reset && (state_q == StFetch) && bus.MemReady;
  assign bus.NextPC    = reset && (state_q == StFetch) && bus.MemReady;
  assign bus.Undef     = (state_q == StDecode) && (bus.Op == 2'b11);
  assign bus.RegW      = ctrl_q.reg_w;
  assign bus.MemW      = ctrl_q.mem_w;
  assign bus.Branch    = ctrl_q.branch;
  assign bus.ALUOp     = ctrl_q.alu_op;
  assign bus.AdrSrc    = ctrl_q.adr_src;
  assign bus.ALUSrcA   = ctrl_q.alu_src_a;
  assign bus.ALUSrcB   = ctrl_q.alu_src_b;
  assign bus.ResultSrc = ctrl_q.result_src;
  assign bus.State     = state_q;

`ifdef MULTICYCLE_FSM_PERF_EN
  logic [15:0] inst_ret_q;
  logic        retire;

  always_comb begin
    retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBranch) ||
             ((state_q == StMemWrite) && bus.MemReady) ||
             ((state_q == StDecode) && (bus.Op == 2'b11));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst_ret_q <= 16'd0;
    end else if (retire) begin
      inst_ret_q <= inst_ret_q + 16'd1;
    end
  end

  assign bus.InstRet = inst_ret_q;
`endif

endmodule

// File: tb/tb_multicycle_fsm.sv
// Scoreboard bench for multicycle_fsm: per-cycle expected state/control pushed by the driver.
// Exercises InstRet too when MULTICYCLE_FSM_PERF_EN is defined.
module tb_multicycle_fsm;

  typedef struct packed {
    logic [15:0] idx;
    logic [3:0]  st;
    logic [13:0] w;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   step_idx;
  exp_t sb[$];

  multicycle_fsm_if bus ();

  multicycle_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Control table straight from the state descriptions:
  // {RegW, MemW, Branch, ALUOp, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
  function automatic logic [13:0] exp_word(input int st, input logic mr, input logic [1:0] op,
                                           input logic rst);
    logic [10:0] c;
    logic        irw;
    logic        und;
    case (st)
      0, 1:    c = 11'b0_0_0_0_0_01_10_10;
      2:       c = 11'b0_0_0_0_0_00_01_00;
      3:       c = 11'b0_0_0_0_1_00_00_00;
      4:       c = 11'b1_0_0_0_0_00_00_01;
      5:       c = 11'b0_1_0_0_1_00_00_00;
      6:       c = 11'b0_0_0_1_0_00_00_00;
      7:       c = 11'b0_0_0_1_0_00_01_00;
      8:       c = 11'b1_0_0_0_0_00_00_00;
      9:       c = 11'b0_0_1_0_0_00_01_10;
      default: c = 11'b0;
    endcase
    irw = (st == 0) && mr && rst;
    und = (st == 1) && (op == 2'b11);
    return {irw, irw, c, und};
  endfunction

  // Drive one cycle's inputs at the falling edge and record what the DUT should show.
  task automatic cyc(input logic rst, input logic [1:0] op, input logic [5:0] fn,
                     input logic mr, input int st);
    exp_t e;
    @(negedge clk);
    reset        = rst;
    bus.Op       = op;
    bus.Funct    = fn;
    bus.MemReady = mr;
    e.idx = 16'(step_idx);
    e.st  = 4'(st);
    e.w   = exp_word(st, mr, op, rst);
    sb.push_back(e);
    step_idx++;
  endtask

  initial begin
    exp_t e;
    logic [13:0] got;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp, bus.AdrSrc,
               bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.Undef};
        check_eq($sformatf("state@%0d", e.idx), 32'(bus.State), 32'(e.st));
        check_eq($sformatf("ctrl@%0d", e.idx), 32'(got), 32'(e.w));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    step_idx     = 0;
    reset        = 1'b0;
    bus.Op       = 2'b00;
    bus.Funct    = 6'b0;
    bus.MemReady = 1'b1;

    // Reset held with MemReady high: fetch strobes stay low
    cyc(1'b0, 2'b00, 6'b000000, 1'b1, 0);
    cyc(1'b0, 2'b00, 6'b000000, 1'b1, 0);
    // Load, MemReady high: 0,1,2,3,4
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 0);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 1);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 2);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 3);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 4);
    // Store with three wait cycles in MEMWRITE
    cyc(1'b1, 2'b01, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b01, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b01, 6'b000000, 1'b1, 2);
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b01, 6'b000000, 1'b0, 5);
    cyc(1'b1, 2'b01, 6'b000000, 1'b1, 5);
    // Data processing, immediate then register
    cyc(1'b1, 2'b00, 6'b100000, 1'b1, 0);
    cyc(1'b1, 2'b00, 6'b100000, 1'b1, 1);
    cyc(1'b1, 2'b00, 6'b100000, 1'b1, 7);
    cyc(1'b1, 2'b00, 6'b100000, 1'b1, 8);
    cyc(1'b1, 2'b00, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b00, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b00, 6'b000000, 1'b1, 6);
    cyc(1'b1, 2'b00, 6'b000000, 1'b1, 8);
    // Branch
    cyc(1'b1, 2'b10, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b10, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b10, 6'b000000, 1'b1, 9);
    // Undefined
    cyc(1'b1, 2'b11, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b11, 6'b000000, 1'b1, 1);
    // Fetch stall, then load with a read stall
    cyc(1'b1, 2'b01, 6'b000001, 1'b0, 0);
    cyc(1'b1, 2'b01, 6'b000001, 1'b0, 0);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 0);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 1);
    cyc(1'b1, 2'b01, 6'b000001, 1'b0, 2);
    cyc(1'b1, 2'b01, 6'b000001, 1'b0, 3);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 3);
    cyc(1'b1, 2'b01, 6'b000001, 1'b1, 4);
    // Reset during a stalled store aborts it at once
    cyc(1'b1, 2'b01, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b01, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b01, 6'b000000, 1'b0, 2);
    cyc(1'b1, 2'b01, 6'b000000, 1'b0, 5);
    cyc(1'b0, 2'b01, 6'b000000, 1'b0, 0);
    cyc(1'b0, 2'b01, 6'b000000, 1'b1, 0);
    // First edge after release evaluates FETCH
    cyc(1'b1, 2'b10, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b10, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b10, 6'b000000, 1'b1, 9);
    cyc(1'b1, 2'b10, 6'b000000, 1'b0, 0);

`ifdef MULTICYCLE_FSM_PERF_EN
    cyc(1'b0, 2'b11, 6'b000000, 1'b0, 0);
    @(negedge clk);
    #2;
    check_eq("instret_reset", 32'(bus.InstRet), 32'h0);
    cyc(1'b1, 2'b11, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b11, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b11, 6'b000000, 1'b0, 0);
    #2;
    check_eq("instret_one", 32'(bus.InstRet), 32'h1);
    force dut.inst_ret_q = 16'hFFFF;
    #1;
    release dut.inst_ret_q;
    check_eq("instret_preload", 32'(bus.InstRet), 32'hFFFF);
    cyc(1'b1, 2'b11, 6'b000000, 1'b1, 0);
    cyc(1'b1, 2'b11, 6'b000000, 1'b1, 1);
    cyc(1'b1, 2'b11, 6'b000000, 1'b0, 0);
    #2;
    check_eq("instret_wrap", 32'(bus.InstRet), 32'h0);
`endif

    @(negedge clk);
    #4;
    check_eq("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports clk and reset.
REQ-002 The block SHALL provide these ports (name  direction  width  meaning):
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset
- Op  input  2  instruction class from IR[27:26]
- Funct  input  6  IR[25:20]; Funct[5]=I (immediate), Funct[0]=S/L (load)
- MemReady  input  1  memory completes the current access this cycle
- IRWrite  output  1  load instruction register
- NextPC  output  1  write PC+4
- RegW  output  1  register write request (gated downstream by condlogic)
- MemW  output  1  memory write request (gated downstream by condlogic)
- Branch  output  1  branch request
- ALUOp  output  1  ALU decoder enable (0 = add)
- AdrSrc  output  1  0 = PC, 1 = ALU result register
- ALUSrcA  output  2  ALU A operand select
- ALUSrcB  output  2  ALU B operand select
- ResultSrc  output  2  result mux select
- Undef  output  1  one-cycle pulse on undefined Op
- State  output  4  current state encoding

Function
REQ-003 The block SHALL implement a registered state machine with encodings FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; encodings 10-15 SHALL go to FETCH on the next edge with all enables 0.
REQ-004 FETCH SHALL drive AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=0, ResultSrc=10; IRWrite=NextPC=MemReady; it SHALL stay in FETCH while MemReady=0 and go to DECODE when MemReady=1.
REQ-005 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
- Op=01 -> MEMADR.
- Op=00 with Funct[5]=0 -> EXECUTER.
- Op=00 with Funct[5]=1 -> EXECUTEI.
- Op=10 -> BRANCH.
- Op=11 -> FETCH with Undef=1 for that cycle.
REQ-006 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=0; it SHALL go to MEMREAD if Funct[0]=1, else to MEMWRITE.
REQ-007 MEMREAD SHALL drive AdrSrc=1, ResultSrc=00; it SHALL hold while MemReady=0 and go to MEMWB when MemReady=1.
REQ-008 MEMWB SHALL drive ResultSrc=01, RegW=1, then go to FETCH.
REQ-009 MEMWRITE SHALL drive AdrSrc=1, ResultSrc=00, MemW=1 continuously until the cycle where MemReady=1, then go to FETCH.
REQ-010 EXECUTER SHALL drive ALUSrcA=00, ALUSrcB=00, ALUOp=1; EXECUTEI SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=1; both SHALL go to ALUWB.
REQ-011 ALUWB SHALL drive ResultSrc=00, RegW=1, then go to FETCH.
REQ-012 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ALUOp=0, ResultSrc=10, Branch=1, then go to FETCH.
REQ-013 Outputs not listed for a state SHALL be 0.
REQ-014 Only IRWrite and NextPC SHALL depend combinationally on MemReady; all other outputs SHALL depend on state only.
REQ-015 Instruction latency with MemReady tied high SHALL be:
- load: 5 cycles
- store: 4 cycles
- data processing: 4 cycles
- branch: 3 cycles
- undefined: 2 cycles

Reset
REQ-016 While reset=0, the state SHALL be FETCH; IRWrite, NextPC, RegW, MemW, Branch and Undef SHALL be 0 regardless of MemReady, and State SHALL read 0.
REQ-017 Reset asserted mid-instruction SHALL abort immediately with no further write-enable pulse.
REQ-018 The first edge after reset deassertion SHALL evaluate FETCH.

Configuration
REQ-019 With MULTICYCLE_FSM_PERF_EN defined, the block SHALL add output InstRet (16 bits), which increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH or DECODE(Op=11).
REQ-020 InstRet SHALL wrap from 0xFFFF to 0x0000 and SHALL clear on reset.
REQ-021 Without MULTICYCLE_FSM_PERF_EN, InstRet SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset low, MemReady=1: IRWrite=0, State=0; release reset, next cycle IRWrite=1, NextPC=1.
- Op=01, Funct=000001, MemReady=1: states 0,1,2,3,4,0; RegW=1 only in MEMWB with ResultSrc=01.
- Op=01, Funct=000000, MemReady low for 3 cycles in MEMWRITE: MemW=1 for 4 cycles, then FETCH.
- Op=00, Funct=100000: states 0,1,7,8,0 with ALUSrcB=01, ALUOp=1 in EXECUTEI; Op=10: Branch=1 for exactly 1 cycle.
- Op=11: Undef pulses 1 cycle in DECODE, no RegW/MemW; with PERF_EN, InstRet preloaded 0xFFFF reads 0x0000 after retire.
- reset=0 asserted while in MEMWRITE with MemW=1: MemW drops within the same cycle, State=0.
